instr_fetch_unit: RTL and testbench

Front-end stage directly upstream of the control unit. Owns the program counter and fetches 32-bit MIPS words from instruction memory over a req/ack handshake. Splits each word into fields, holds them stable until the control unit reports completion, and drives OpCode = NOP (63) whenever no instruction is held, so the control unit idles in its fetch state.

---
 rtl/instr_fetch_unit_pkg.sv | 29 ++
 rtl/instr_fetch_unit_field_split.sv | 26 ++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: data width,
// FSM state encodings, MIPS field bit positions and the NOP opcode.
package instr_fetch_unit_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] NOP_OPCODE = 6'd63;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

endpackage

// File: rtl/instr_fetch_unit_field_split.sv
// Combinational MIPS field extraction. The opcode is forced to NOP whenever
// no live instruction is present so a downstream decoder simply idles.
module instr_field_split
  import instr_fetch_unit_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  input  logic              valid,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm
);

  // Imm overlaps Rd/Shamt/Funct on purpose; the decoder picks the view it needs.
  assign opcode = valid ? instr[OP_MSB:OP_LSB] : NOP_OPCODE;
  assign rs     = instr[RS_MSB:RS_LSB];
  assign rt     = instr[RT_MSB:RT_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack
// handshake and holds the decoded fields until the control unit is done.
//
// state  | meaning
// S_REQ  | MEM_REQ high at pc_next, waiting for MEM_ACK (with timeout)
// S_HOLD | instruction held on the field outputs until CU_DONE
// S_HALT | halt word fetched; terminal until reset
// S_ERR  | memory never acknowledged; terminal until reset
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter int          ACK_TIMEOUT = 16,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic              MEM_REQ,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_DATA,
  input  logic              CU_DONE,
  output logic [5:0]        OpCode,
  output logic [4:0]        Rs,
  output logic [4:0]        Rt,
  output logic [4:0]        Rd,
  output logic [4:0]        Shamt,
  output logic [5:0]        Funct,
  output logic [15:0]       Imm,
  output logic [DATA_W-1:0] PC,
  output logic              INSTR_VALID,
  output logic              HALT,
  output logic              ERR
);

  localparam int            CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic [CNT_W-1:0]  ack_cnt;

  // Fetch FSM, PC bookkeeping and ack-timeout counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_REQ;
      pc_next <= RESET_PC;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ack_cnt <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (MEM_ACK) begin
            if (MEM_DATA == HALT_WORD) begin
              state <= S_HALT;
            end else begin
              instr_q <= MEM_DATA;
              pc_q    <= pc_next;
              pc_next <= pc_next + PC_STEP;
              state   <= S_HOLD;
            end
          end else if (ack_cnt == TMO_LAST) begin
            state <= S_ERR;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (CU_DONE) begin
            ack_cnt <= '0;
            state   <= S_REQ;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The request is suppressed during the reset cycle itself so the first
  // request appears only once reset has been released.
  assign MEM_REQ     = (state == S_REQ) && !RST;
  assign MEM_ADDR    = pc_next;
  assign PC          = pc_q;
  assign INSTR_VALID = (state == S_HOLD);
  assign HALT        = (state == S_HALT);
  assign ERR         = (state == S_ERR);

  instr_field_split u_split (
    .instr  (instr_q),
    .valid  (INSTR_VALID),
    .opcode (OpCode),
    .rs     (Rs),
    .rt     (Rt),
    .rd     (Rd),
    .shamt  (Shamt),
    .funct  (Funct),
    .imm    (Imm)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, zero-wait fetch, CU_DONE
// release, wait states, timeout, halt, reset mid-hold and PC wrap.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        cu_done;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc;
  logic        instr_valid, halt, err;

  logic        rst_w;
  logic        mem_ack_w;
  logic [31:0] mem_data_w;
  logic        cu_done_w;
  logic [31:0] mem_addr_w;
  logic        mem_req_w;
  logic [5:0]  opcode_w;
  logic [4:0]  rs_w, rt_w, rd_w, shamt_w;
  logic [5:0]  funct_w;
  logic [15:0] imm_w;
  logic [31:0] pc_w;
  logic        instr_valid_w, halt_w, err_w;

  int passed = 0;
  int total  = 0;

  instr_fetch_unit dut (
    .CLK(clk), .RST(rst), .MEM_ADDR(mem_addr), .MEM_REQ(mem_req),
    .MEM_ACK(mem_ack), .MEM_DATA(mem_data), .CU_DONE(cu_done),
    .OpCode(opcode), .Rs(rs), .Rt(rt), .Rd(rd), .Shamt(shamt),
    .Funct(funct), .Imm(imm), .PC(pc), .INSTR_VALID(instr_valid),
    .HALT(halt), .ERR(err)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .CLK(clk), .RST(rst_w), .MEM_ADDR(mem_addr_w), .MEM_REQ(mem_req_w),
    .MEM_ACK(mem_ack_w), .MEM_DATA(mem_data_w), .CU_DONE(cu_done_w),
    .OpCode(opcode_w), .Rs(rs_w), .Rt(rt_w), .Rd(rd_w), .Shamt(shamt_w),
    .Funct(funct_w), .Imm(imm_w), .PC(pc_w), .INSTR_VALID(instr_valid_w),
    .HALT(halt_w), .ERR(err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_data = '0; cu_done = 1'b0;
    tick();
    tick();
    sample();
    total++; if (mem_req !== 1'b0) $display("FAIL reset_req got=%0b exp=0", mem_req); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", instr_valid); else passed++;
    total++; if (opcode !== 6'd63) $display("FAIL reset_opcode got=%0d exp=63", opcode); else passed++;
    total++; if ({rs, rt, imm} !== 26'd0) $display("FAIL reset_fields got=%h exp=0", {rs, rt, imm}); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", pc); else passed++;
    total++; if ({halt, err} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {halt, err}); else passed++;
    tick();
    rst = 1'b0;
    sample();
    total++; if (mem_req !== 1'b1) $display("FAIL first_req got=%0b exp=1", mem_req); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL first_addr got=%h exp=0", mem_addr); else passed++;
  endtask

  task automatic test_zero_wait_fetch();
    mem_ack = 1'b1; mem_data = 32'h0022_1820;
    tick();
    mem_ack = 1'b0; mem_data = 32'hDEAD_BEEF;
    sample();
    total++; if (instr_valid !== 1'b1) $display("FAIL fetch_valid got=%0b exp=1", instr_valid); else passed++;
    total++; if (opcode !== 6'd0) $display("FAIL fetch_opcode got=%0d exp=0", opcode); else passed++;
    total++; if (rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3) $display("FAIL fetch_regs got=%0d/%0d/%0d exp=1/2/3", rs, rt, rd); else passed++;
    total++; if (shamt !== 5'd0 || funct !== 6'h20) $display("FAIL fetch_funct got=%0d/%h exp=0/20", shamt, funct); else passed++;
    total++; if (imm !== 16'h1820) $display("FAIL fetch_imm got=%h exp=1820", imm); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL fetch_pc got=%h exp=0", pc); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL hold_req got=%0b exp=0", mem_req); else passed++;
  endtask

  task automatic test_cu_done();
    // A stray ack while holding must be ignored.
    mem_ack = 1'b1; mem_data = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      total++; if (instr_valid !== 1'b1 || imm !== 16'h1820 || rs !== 5'd1) $display("FAIL hold_stable cyc=%0d got=%0b/%h/%0d exp=1/1820/1", i, instr_valid, imm, rs); else passed++;
    end
    mem_ack = 1'b0;
    cu_done = 1'b1;
    tick();
    cu_done = 1'b0;
    sample();
    total++; if (opcode !== 6'd63 || instr_valid !== 1'b0) $display("FAIL done_nop got=%0d/%0b exp=63/0", opcode, instr_valid); else passed++;
    tick();
    sample();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) $display("FAIL done_next got=%0b/%h exp=1/4", mem_req, mem_addr); else passed++;
  endtask

  task automatic test_wait_states();
    // Already one cycle into the request at address 4; two more waits.
    for (int i = 0; i < 2; i++) begin
      tick();
      sample();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) $display("FAIL wait_req cyc=%0d got=%0b/%h exp=1/4", i, mem_req, mem_addr); else passed++;
      total++; if (rs !== 5'd1 || imm !== 16'h1820 || err !== 1'b0) $display("FAIL wait_fields cyc=%0d got=%0d/%h/%0b exp=1/1820/0", i, rs, imm, err); else passed++;
    end
    mem_ack = 1'b1; mem_data = 32'h8C43_0010;
    tick();
    mem_ack = 1'b0;
    sample();
    total++; if (opcode !== 6'h23 || rs !== 5'd2 || rt !== 5'd3 || imm !== 16'h0010) $display("FAIL wait_fetch got=%h/%0d/%0d/%h exp=23/2/3/0010", opcode, rs, rt, imm); else passed++;
    total++; if (pc !== 32'h4 || err !== 1'b0) $display("FAIL wait_pc got=%h/%0b exp=4/0", pc, err); else passed++;
    cu_done = 1'b1;
    tick();
    cu_done = 1'b0;
  endtask

  task automatic test_halt();
    sample();
    total++; if (mem_addr !== 32'h8 || mem_req !== 1'b1) $display("FAIL halt_addr got=%h/%0b exp=8/1", mem_addr, mem_req); else passed++;
    mem_ack = 1'b1; mem_data = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    sample();
    total++; if (halt !== 1'b1 || instr_valid !== 1'b0 || opcode !== 6'd63) $display("FAIL halt_state got=%0b/%0b/%0d exp=1/0/63", halt, instr_valid, opcode); else passed++;
    for (int i = 0; i < 4; i++) begin
      cu_done = 1'b1; mem_ack = 1'b1; mem_data = 32'h0;
      tick();
      sample();
      total++; if (mem_req !== 1'b0 || halt !== 1'b1 || instr_valid !== 1'b0) $display("FAIL halt_sticky cyc=%0d got=%0b/%0b/%0b exp=0/1/0", i, mem_req, halt, instr_valid); else passed++;
    end
    cu_done = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    total++; if (halt !== 1'b0 || mem_addr !== 32'h0) $display("FAIL tmo_start got=%0b/%h exp=0/0", halt, mem_addr); else passed++;
    // 15 unacknowledged cycles are tolerated, the 16th trips the error.
    for (int i = 0; i < 15; i++) begin
      tick();
      sample();
      total++; if (err !== 1'b0 || mem_req !== 1'b1) $display("FAIL tmo_early cyc=%0d got=%0b/%0b exp=0/1", i, err, mem_req); else passed++;
    end
    tick();
    sample();
    total++; if (err !== 1'b1 || mem_req !== 1'b0) $display("FAIL tmo_err got=%0b/%0b exp=1/0", err, mem_req); else passed++;
    mem_ack = 1'b1; mem_data = 32'h0022_1820; cu_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      total++; if (err !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL tmo_sticky cyc=%0d got=%0b/%0b/%0b exp=1/0/0", i, err, mem_req, instr_valid); else passed++;
    end
    mem_ack = 1'b0; cu_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    total++; if (err !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL tmo_clear got=%0b/%0b/%h exp=0/1/0", err, mem_req, mem_addr); else passed++;
  endtask

  task automatic test_reset_in_hold();
    mem_ack = 1'b1; mem_data = 32'h0022_1820;
    tick();
    mem_ack = 1'b0; cu_done = 1'b1;
    tick();
    cu_done = 1'b0; mem_ack = 1'b1; mem_data = 32'h8C43_0010;
    tick();
    mem_ack = 1'b0;
    sample();
    total++; if (pc !== 32'h4 || instr_valid !== 1'b1) $display("FAIL pre_rst got=%h/%0b exp=4/1", pc, instr_valid); else passed++;
    rst = 1'b1; mem_ack = 1'b1; cu_done = 1'b1;
    tick();
    sample();
    total++; if (pc !== 32'h0 || instr_valid !== 1'b0 || opcode !== 6'd63) $display("FAIL rst_hold got=%h/%0b/%0d exp=0/0/63", pc, instr_valid, opcode); else passed++;
    total++; if ({rs, rt, imm} !== 26'd0 || mem_req !== 1'b0) $display("FAIL rst_hold_fields got=%h/%0b exp=0/0", {rs, rt, imm}, mem_req); else passed++;
    rst = 1'b0; mem_ack = 1'b0; cu_done = 1'b0;
    sample();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL rst_hold_restart got=%0b/%h exp=1/0", mem_req, mem_addr); else passed++;
  endtask

  task automatic test_pc_wrap();
    rst_w = 1'b1;
    tick();
    rst_w = 1'b0;
    sample();
    total++; if (mem_addr_w !== 32'hFFFF_FFFC || mem_req_w !== 1'b1) $display("FAIL wrap_first got=%h/%0b exp=fffffffc/1", mem_addr_w, mem_req_w); else passed++;
    mem_ack_w = 1'b1; mem_data_w = 32'h2000_0005;
    tick();
    mem_ack_w = 1'b0;
    sample();
    total++; if (pc_w !== 32'hFFFF_FFFC || opcode_w !== 6'd8) $display("FAIL wrap_pc got=%h/%0d exp=fffffffc/8", pc_w, opcode_w); else passed++;
    cu_done_w = 1'b1;
    tick();
    cu_done_w = 1'b0;
    sample();
    total++; if (mem_addr_w !== 32'h0 || mem_req_w !== 1'b1) $display("FAIL wrap_next got=%h/%0b exp=0/1", mem_addr_w, mem_req_w); else passed++;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_data = '0; cu_done = 1'b0;
    rst_w = 1'b1; mem_ack_w = 1'b0; mem_data_w = '0; cu_done_w = 1'b0;
    test_reset();
    test_zero_wait_fetch();
    test_cu_done();
    test_wait_states();
    test_halt();
    test_timeout();
    test_reset_in_hold();
    test_pc_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
